// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the IF stage's control inputs and its IF/ID-register outputs.
//
//   Control semantics (there is no valid/ready pair on this bus):
//     stall     - level, sampled on the rising clock edge; while high the stage
//                 holds its PC and every output.
//     redirect  - level, sampled on the rising clock edge; loads redirectTarget
//                 into the PC and issues one bubble. It takes priority over a
//                 stall in the same cycle.
//     instValid - qualifies instOut; 0 means instOut carries the bubble word.
//
//   Signals
//     stall, redirect, redirectTarget[31:0]        hazard/branch unit -> IF
//     instOut[31:0], pcOut[31:0], pcPlus4[31:0],   IF -> IF/ID consumer
//     instValid, fetchCount[31:0], fetchFault
//
//   Modports
//     master : the fetch stage itself
//     slave  : the surrounding pipeline (drives control, reads the fetch)
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        instValid;
  logic [31:0] fetchCount;
  logic        fetchFault;

  modport master (
    input  stall,
    input  redirect,
    input  redirectTarget,
    output instOut,
    output pcOut,
    output pcPlus4,
    output instValid,
    output fetchCount,
    output fetchFault
  );

  modport slave (
    output stall,
    output redirect,
    output redirectTarget,
    input  instOut,
    input  pcOut,
    input  pcPlus4,
    input  instValid,
    input  fetchCount,
    input  fetchFault
  );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   IF stage of a 5-stage MIPS pipeline. Owns the program counter, reads the
//   instruction ROM combinationally at pc[31:2] and registers the fetched word
//   (with its PC, PC+4 and a valid flag) for the IF/ID register.
//
//   Per rising edge, priority is reset > redirect > stall > normal fetch.
//   A redirect drops the wrong-path word and issues NOP_WORD with
//   instValid=0. A fetch whose word index is at or beyond MEM_DEPTH returns
//   NOP_WORD, sets the sticky fetchFault and still advances the PC.
//
//   Parameters
//     MEM_DEPTH  ROM depth in 32-bit words (power of 2)
//     ROM_IMAGE  ROM contents, word i at bits [32*i +: 32]; fixed at
//                elaboration, never written at run time
//     RESET_PC   PC loaded on reset (word aligned)
//     NOP_WORD   bubble instruction (sll $0,$0,0)
//
//   Ports
//     clock  in  rising-edge clock
//     reset  in  synchronous, active-high reset
//     bus    instruction_fetch_if.master (control in, fetched word out)
//
//   Every output is a flop, so there is no combinational path from stall or
//   redirect to any output.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                       MEM_DEPTH = 64,
  parameter logic [MEM_DEPTH*32-1:0]  ROM_IMAGE = '0,
  parameter logic [31:0]              RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]              NOP_WORD  = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] pc;
  logic [31:0] word_addr;
  logic [31:0] rom_word;
  logic [31:0] pc_next_seq;
  logic [31:0] redirect_pc;
  logic        in_range;

  // ROM read and address arithmetic are purely combinational on the pc reg.
  // The full word address is range-checked so that addresses aliasing into
  // the ROM through the dropped upper bits are still reported as faults.
  always_comb begin
    word_addr   = pc >> 2;
    in_range    = (word_addr < 32'(MEM_DEPTH));
    rom_word    = ROM_IMAGE[32*int'(word_addr[AW-1:0]) +: 32];
    pc_next_seq = pc + 32'd4;
    redirect_pc = bus.redirectTarget & ~32'h0000_0003;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_PC;
      bus.instOut    <= NOP_WORD;
      bus.pcOut      <= 32'h0000_0000;
      bus.pcPlus4    <= 32'h0000_0000;
      bus.instValid  <= 1'b0;
      bus.fetchCount <= 32'h0000_0000;
      bus.fetchFault <= 1'b0;
    end else if (bus.redirect) begin
      // Squash the wrong-path word; pcOut/pcPlus4 keep describing the last
      // real fetch so downstream link math is not disturbed by the bubble.
      pc            <= redirect_pc;
      bus.instOut   <= NOP_WORD;
      bus.instValid <= 1'b0;
    end else if (!bus.stall) begin
      pc          <= pc_next_seq;
      bus.pcOut   <= pc;
      bus.pcPlus4 <= pc_next_seq;
      if (in_range) begin
        bus.instOut    <= rom_word;
        bus.instValid  <= 1'b1;
        bus.fetchCount <= bus.fetchCount + 32'd1;
      end else begin
        bus.instOut    <= NOP_WORD;
        bus.instValid  <= 1'b0;
        bus.fetchFault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Drives two instruction_fetch instances with identical control: one with
//   a 64-word ROM and one with a 4-word ROM (exercises the fault path). A
//   per-instance reference model computes the expected registered outputs
//   when stimulus is driven; they are queued and compared after the edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int          W        = 130;  // {inst,pcout,pcp4,count,valid,fault}

  // Distinct, non-NOP contents per instance.
  function automatic logic [31:0] img_word(input int s, input int i);
    if (s == 0) return 32'hA000_0000 + 32'(i) * 32'h0001_0101;
    else        return 32'h5B00_0000 + 32'(i) * 32'h0000_0011;
  endfunction

  function automatic logic [64*32-1:0] mk_img(input int s, input int depth);
    logic [64*32-1:0] v;
    v = '0;
    for (int i = 0; i < depth; i++) v[i*32 +: 32] = img_word(s, i);
    return v;
  endfunction

  localparam logic [64*32-1:0] IMG0 = mk_img(0, 64);
  localparam logic [4*32-1:0]  IMG1 = 128'(mk_img(1, 4));

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  instruction_fetch_if ifc0 ();
  instruction_fetch_if ifc1 ();

  instruction_fetch #(
    .MEM_DEPTH (64),
    .ROM_IMAGE (IMG0),
    .RESET_PC  (RESET_PC),
    .NOP_WORD  (NOP_WORD)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc0.master)
  );

  instruction_fetch #(
    .MEM_DEPTH (4),
    .ROM_IMAGE (IMG1),
    .RESET_PC  (RESET_PC),
    .NOP_WORD  (NOP_WORD)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc1.master)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  int          m_depth [2] = '{64, 4};
  logic [31:0] m_pc    [2];
  logic [31:0] m_inst  [2];
  logic [31:0] m_pcout [2];
  logic [31:0] m_pcp4  [2];
  logic [31:0] m_cnt   [2];
  logic        m_valid [2];
  logic        m_fault [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge of instance s.
  task automatic model_edge(input int s, input logic rst, input logic stl,
                            input logic rdr, input logic [31:0] tgt);
    if (rst) begin
      m_pc[s]    = RESET_PC;
      m_inst[s]  = NOP_WORD;
      m_pcout[s] = 32'h0;
      m_pcp4[s]  = 32'h0;
      m_cnt[s]   = 32'h0;
      m_valid[s] = 1'b0;
      m_fault[s] = 1'b0;
    end else if (rdr) begin
      m_pc[s]    = {tgt[31:2], 2'b00};
      m_inst[s]  = NOP_WORD;
      m_valid[s] = 1'b0;
    end else if (!stl) begin
      if ((m_pc[s] >> 2) < 32'(m_depth[s])) begin
        m_inst[s]  = img_word(s, int'(m_pc[s] >> 2));
        m_valid[s] = 1'b1;
        m_cnt[s]   = m_cnt[s] + 32'd1;
      end else begin
        m_inst[s]  = NOP_WORD;
        m_valid[s] = 1'b0;
        m_fault[s] = 1'b1;
      end
      m_pcout[s] = m_pc[s];
      m_pcp4[s]  = m_pc[s] + 32'd4;
      m_pc[s]    = m_pc[s] + 32'd4;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic stl, input logic rdr,
                      input logic [31:0] tgt);
    logic [W-1:0] e;
    logic [31:0]  o_inst, o_pc, o_p4, o_cnt;
    logic         o_v, o_f;
    @(negedge clock);
    reset               = rst;
    ifc0.stall          = stl;
    ifc0.redirect       = rdr;
    ifc0.redirectTarget = tgt;
    ifc1.stall          = stl;
    ifc1.redirect       = rdr;
    ifc1.redirectTarget = tgt;
    for (int s = 0; s < 2; s++) begin
      model_edge(s, rst, stl, rdr, tgt);
      exp_q.push_back({m_inst[s], m_pcout[s], m_pcp4[s], m_cnt[s], m_valid[s], m_fault[s]});
    end
    @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        o_inst = ifc0.instOut; o_pc = ifc0.pcOut; o_p4 = ifc0.pcPlus4;
        o_cnt = ifc0.fetchCount; o_v = ifc0.instValid; o_f = ifc0.fetchFault;
      end else begin
        o_inst = ifc1.instOut; o_pc = ifc1.pcOut; o_p4 = ifc1.pcPlus4;
        o_cnt = ifc1.fetchCount; o_v = ifc1.instValid; o_f = ifc1.fetchFault;
      end
      if (exp_q.size() == 0) begin
        check($sformatf("d%0d_queue_empty", s), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("d%0d_instOut", s),    o_inst,       e[129:98]);
        check($sformatf("d%0d_pcOut", s),      o_pc,         e[97:66]);
        check($sformatf("d%0d_pcPlus4", s),    o_p4,         e[65:34]);
        check($sformatf("d%0d_fetchCount", s), o_cnt,        e[33:2]);
        check($sformatf("d%0d_instValid", s),  32'(o_v),     32'(e[1]));
        check($sformatf("d%0d_fetchFault", s), 32'(o_f),     32'(e[0]));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_stl, r_rdr;
    logic [31:0] r_tgt;
    int          r;
    reset               = 1'b1;
    ifc0.stall          = 1'b0;
    ifc0.redirect       = 1'b0;
    ifc0.redirectTarget = 32'h0;
    ifc1.stall          = 1'b0;
    ifc1.redirect       = 1'b0;
    ifc1.redirectTarget = 32'h0;

    // Reset values, then in-order fetch with a two-cycle stall after B.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(2);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    run(2);

    // Redirect to an unaligned target after A: bubble, then ROM[4].
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0012);
    run(2);

    // Redirect with simultaneous stall: redirect wins.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0008);
    run(2);

    // Small ROM runs off the end and faults; fault is sticky, reset clears it.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(7);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(2);

    // Reset during a stall with pc=0x20, and reset together with redirect.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(8);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    run(2);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    run(1);

    // PC wrap at 2^32: redirect to the last word, fetch through the wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(3);

    // Randomised mix of fetch, stall and redirect (some targets out of range).
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 60; i++) begin
      r     = $urandom_range(0, 9);
      r_stl = (r < 3);
      r_rdr = (r >= 8);
      r_tgt = 32'($urandom_range(0, 80)) * 32'd4 + 32'($urandom_range(0, 3));
      step(1'b0, r_stl, r_rdr, r_tgt);
    end

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
